// File: rtl/tx_trainerror_hs_if.sv
// Sideband bus bundle between the TRAINERROR initiator and the SB encoder/decoder.
// master: initiator (drives o_encoded_SB_msg_tx/o_valid_tx); slave: SB side.
//
// Signals:
//   i_rx_msg_valid      decoded partner message valid this cycle
//   i_decoded_SB_msg    decoded partner message code
//   i_SB_Busy           SB transmitter busy
//   i_falling_edge_busy SB consumed the current message (1-cycle pulse)
//   i_rx_valid          RX responder currently holds the SB bus
//   o_encoded_SB_msg_tx message code to the SB encoder
//   o_valid_tx          request to the SB to send o_encoded_SB_msg_tx
interface tx_trainerror_hs_if #(
    parameter int SB_MSG_WIDTH = 4
);
    logic                    i_rx_msg_valid;
    logic [SB_MSG_WIDTH-1:0] i_decoded_SB_msg;
    logic                    i_SB_Busy;
    logic                    i_falling_edge_busy;
    logic                    i_rx_valid;
    logic [SB_MSG_WIDTH-1:0] o_encoded_SB_msg_tx;
    logic                    o_valid_tx;

    modport master (
        input  i_rx_msg_valid,
        input  i_decoded_SB_msg,
        input  i_SB_Busy,
        input  i_falling_edge_busy,
        input  i_rx_valid,
        output o_encoded_SB_msg_tx,
        output o_valid_tx
    );

    modport slave (
        output i_rx_msg_valid,
        output i_decoded_SB_msg,
        output i_SB_Busy,
        output i_falling_edge_busy,
        output i_rx_valid,
        input  o_encoded_SB_msg_tx,
        input  o_valid_tx
    );
endinterface

// File: rtl/tx_trainerror_hs.sv
// TRAINERROR initiator: sends TRAINERROR_entry_req, waits for the partner's
// entry_resp, then reports completion or a timeout to the LTSM.
//
// Ports:
//   i_clk               clock, rising edge
//   i_rst               asynchronous active-high reset
//   i_trainerror_en     LTSM enable; low returns the block to IDLE
//   sb                  sideband bundle (master side), see tx_trainerror_hs_if
//   o_trainerror_end_tx handshake complete (level)
//   o_timeout           no response within TIMEOUT_CYCLES (level)
module tx_trainerror_hs #(
    parameter int SB_MSG_WIDTH   = 4,
    parameter int TIMEOUT_CYCLES = 800000,
    parameter int CNT_WIDTH      = 20
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic               i_trainerror_en,
    tx_trainerror_hs_if.master sb,
    output logic               o_trainerror_end_tx,
    output logic               o_timeout
);

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_SEND_REQ  = 3'd1,
        ST_WAIT_RESP = 3'd2,
        ST_FINISHED  = 3'd3,
        ST_TIMEOUT   = 3'd4
    } state_e;

    localparam logic [SB_MSG_WIDTH-1:0] MSG_REQ  = SB_MSG_WIDTH'(15);
    localparam logic [SB_MSG_WIDTH-1:0] MSG_RESP = SB_MSG_WIDTH'(14);
    localparam logic [SB_MSG_WIDTH-1:0] MSG_NONE = '0;
    localparam logic [CNT_WIDTH-1:0]    CNT_LIM  =
        CNT_WIDTH'(TIMEOUT_CYCLES - 1);

    state_e                  state_q, state_d;
    logic [SB_MSG_WIDTH-1:0] code_q, code_d;
    logic                    valid_q, valid_d;
    logic                    valid_dly_q;
    logic                    end_q, end_d;
    logic                    to_q, to_d;
    logic                    pend_q, pend_d;
    logic                    seen_q, seen_d;
    logic [CNT_WIDTH-1:0]    cnt_q, cnt_d;

    logic resp_hit;
    logic fall_valid;
    logic at_limit;
    logic launch;
    logic blocked;
    logic req_now;

    assign resp_hit   = sb.i_rx_msg_valid &&
                        (sb.i_decoded_SB_msg == MSG_RESP);
    // o_valid_tx dropped on the previous edge: SB has taken the request
    assign fall_valid = valid_dly_q && !valid_q;
    assign at_limit   = (cnt_q == CNT_LIM);
    assign blocked    = sb.i_SB_Busy || sb.i_rx_valid;

    // Next-state logic
    always_comb begin
        state_d = state_q;
        if (!i_trainerror_en) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    state_d = ST_SEND_REQ;
                end
                ST_SEND_REQ: begin
                    if (fall_valid) begin
                        state_d = ST_WAIT_RESP;
                    end else if (at_limit) begin
                        state_d = ST_TIMEOUT;
                    end
                end
                ST_WAIT_RESP: begin
                    // a response on the limit cycle still completes
                    if (resp_hit || seen_q) begin
                        state_d = ST_FINISHED;
                    end else if (at_limit) begin
                        state_d = ST_TIMEOUT;
                    end
                end
                ST_FINISHED: state_d = ST_FINISHED;
                ST_TIMEOUT:  state_d = ST_TIMEOUT;
                default:     state_d = ST_IDLE;
            endcase
        end
    end

    assign launch = (state_q == ST_IDLE) && (state_d == ST_SEND_REQ);

    // A deferred request only fires while the FSM stays in SEND_REQ, so an
    // abort or timeout never lets a stale pending request reach the bus.
    assign req_now = launch ||
                     (pend_q && (state_q == ST_SEND_REQ) &&
                      (state_d == ST_SEND_REQ));

    // Registered-output next values
    always_comb begin
        code_d  = code_q;
        valid_d = valid_q;
        end_d   = end_q;
        to_d    = to_q;
        pend_d  = pend_q;
        seen_d  = seen_q;
        cnt_d   = cnt_q;

        if (state_q == ST_IDLE) begin
            code_d  = MSG_NONE;
            valid_d = 1'b0;
            end_d   = 1'b0;
            to_d    = 1'b0;
            pend_d  = 1'b0;
            seen_d  = 1'b0;
            cnt_d   = '0;
        end

        if (launch) begin
            code_d = MSG_REQ;
            if (blocked) begin
                pend_d = 1'b1;
            end
        end

        // remember a response that overtakes the SB consume pulse
        if ((state_q == ST_SEND_REQ) && resp_hit) begin
            seen_d = 1'b1;
        end

        if (((state_q == ST_SEND_REQ) && (state_d == ST_WAIT_RESP) &&
             seen_q) ||
            ((state_q == ST_WAIT_RESP) && (state_d == ST_FINISHED))) begin
            end_d = 1'b1;
        end

        if ((state_d == ST_TIMEOUT) && (state_q != ST_TIMEOUT)) begin
            to_d = 1'b1;
        end

        if (((state_q == ST_SEND_REQ) || (state_q == ST_WAIT_RESP)) &&
            !at_limit) begin
            cnt_d = cnt_q + CNT_WIDTH'(1);
        end

        // SB handshake: consume pulse beats a new request
        if (sb.i_falling_edge_busy) begin
            valid_d = 1'b0;
        end else if (req_now && !blocked) begin
            valid_d = 1'b1;
            pend_d  = 1'b0;
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q     <= ST_IDLE;
            code_q      <= '0;
            valid_q     <= 1'b0;
            valid_dly_q <= 1'b0;
            end_q       <= 1'b0;
            to_q        <= 1'b0;
            pend_q      <= 1'b0;
            seen_q      <= 1'b0;
            cnt_q       <= '0;
        end else begin
            state_q     <= state_d;
            code_q      <= code_d;
            valid_q     <= valid_d;
            valid_dly_q <= valid_q;
            end_q       <= end_d;
            to_q        <= to_d;
            pend_q      <= pend_d;
            seen_q      <= seen_d;
            cnt_q       <= cnt_d;
        end
    end

    assign sb.o_encoded_SB_msg_tx = code_q;
    assign sb.o_valid_tx          = valid_q;
    assign o_trainerror_end_tx    = end_q;
    assign o_timeout              = to_q;

endmodule

// File: tb/tb_tx_trainerror_hs.sv
// Directed/randomized bench for tx_trainerror_hs (TIMEOUT_CYCLES=16).
// Expected values come from the handshake timing rules, counted in edges.
module tb_tx_trainerror_hs;

    localparam int T = 16;

    logic i_clk = 1'b0;
    logic i_rst;
    logic en;
    logic end_o;
    logic to_o;

    int nvec = 0;
    int nerr = 0;

    tx_trainerror_hs_if #(.SB_MSG_WIDTH(4)) sb ();

    tx_trainerror_hs #(
        .SB_MSG_WIDTH   (4),
        .TIMEOUT_CYCLES (T),
        .CNT_WIDTH      (5)
    ) dut (
        .i_clk               (i_clk),
        .i_rst               (i_rst),
        .i_trainerror_en     (en),
        .sb                  (sb),
        .o_trainerror_end_tx (end_o),
        .o_timeout           (to_o)
    );

    always #5 i_clk = ~i_clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        nvec++;
        assert (got === exp) else begin
            nerr++;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic chk_all(input string tag, input int code,
                           input bit v, input bit e, input bit t);
        chk({tag, ".code"}, 32'(sb.o_encoded_SB_msg_tx), 32'(code));
        chk({tag, ".valid"}, 32'(sb.o_valid_tx), 32'(v));
        chk({tag, ".end"}, 32'(end_o), 32'(e));
        chk({tag, ".timeout"}, 32'(to_o), 32'(t));
    endtask

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic quiet();
        sb.i_rx_msg_valid      = 1'b0;
        sb.i_decoded_SB_msg    = 4'd0;
        sb.i_SB_Busy           = 1'b0;
        sb.i_falling_edge_busy = 1'b0;
        sb.i_rx_valid          = 1'b0;
    endtask

    task automatic send_msg(input int code);
        sb.i_rx_msg_valid   = 1'b1;
        sb.i_decoded_SB_msg = 4'(code);
        tick();
        sb.i_rx_msg_valid   = 1'b0;
        sb.i_decoded_SB_msg = 4'd0;
    endtask

    task automatic pulse_feb();
        sb.i_falling_edge_busy = 1'b1;
        tick();
        sb.i_falling_edge_busy = 1'b0;
    endtask

    // en low: IDLE after one edge, outputs cleared on the next
    task automatic abort(input string tag);
        en = 1'b0;
        tick();
        tick();
        chk_all({tag, ".abort"}, 0, 0, 0, 0);
    endtask

    task automatic run_nominal(input string tag);
        int hold;
        int d;
        hold = $urandom_range(0, 4);
        d    = $urandom_range(0, 5);
        en = 1'b1;
        tick();
        chk_all({tag, ".launch"}, 15, 1, 0, 0);
        repeat (hold) begin
            tick();
            chk({tag, ".hold"}, 32'(sb.o_valid_tx), 32'd1);
        end
        pulse_feb();
        chk({tag, ".feb_valid"}, 32'(sb.o_valid_tx), 32'd0);
        chk({tag, ".feb_end"}, 32'(end_o), 32'd0);
        tick();
        chk({tag, ".wait_end"}, 32'(end_o), 32'd0);
        repeat (d) begin
            send_msg($urandom_range(0, 13));
            chk({tag, ".other"}, 32'(end_o), 32'd0);
        end
        send_msg(14);
        chk_all({tag, ".resp"}, 15, 0, 1, 0);
        tick();
        chk_all({tag, ".done"}, 15, 0, 1, 0);
    endtask

    initial begin
        int nb;
        int k;
        bit withfeb;

        i_rst = 1'b1;
        en    = 1'b0;
        quiet();
        tick();
        chk_all("reset", 0, 0, 0, 0);
        tick();
        i_rst = 1'b0;
        tick();
        chk_all("idle", 0, 0, 0, 0);

        // 1 nominal handshake
        run_nominal("nom");
        abort("nom");

        // 2 SB busy defers the request
        nb = $urandom_range(1, 8);
        sb.i_SB_Busy = 1'b1;
        en = 1'b1;
        repeat (nb) begin
            tick();
            chk("busy.valid", 32'(sb.o_valid_tx), 32'd0);
            chk("busy.code", 32'(sb.o_encoded_SB_msg_tx), 32'd15);
        end
        sb.i_SB_Busy = 1'b0;
        tick();
        chk_all("busy.rise", 15, 1, 0, 0);
        tick();
        chk("busy.keep", 32'(sb.o_valid_tx), 32'd1);
        abort("busy");

        // 3 RX responder owns the bus
        nb = $urandom_range(1, 6);
        sb.i_rx_valid = 1'b1;
        en = 1'b1;
        repeat (nb) begin
            tick();
            chk("rxc.held", 32'(sb.o_valid_tx), 32'd0);
        end
        sb.i_rx_valid = 1'b0;
        tick();
        chk_all("rxc.rise", 15, 1, 0, 0);
        tick();
        chk("rxc.keep", 32'(sb.o_valid_tx), 32'd1);
        pulse_feb();
        chk("rxc.fall", 32'(sb.o_valid_tx), 32'd0);
        repeat (4) begin
            tick();
            chk("rxc.once", 32'(sb.o_valid_tx), 32'd0);
        end
        send_msg(14);
        chk_all("rxc.resp", 15, 0, 1, 0);
        abort("rxc");

        // 4 response arrives before the SB consume pulse
        k = $urandom_range(0, 3);
        en = 1'b1;
        tick();
        tick();
        send_msg(14);
        chk("early.noend", 32'(end_o), 32'd0);
        repeat (k) begin
            tick();
            chk("early.wait", 32'(end_o), 32'd0);
            chk("early.valid", 32'(sb.o_valid_tx), 32'd1);
        end
        pulse_feb();
        chk("early.feb_end", 32'(end_o), 32'd0);
        chk("early.feb_valid", 32'(sb.o_valid_tx), 32'd0);
        tick();
        chk_all("early.end", 15, 0, 1, 0);
        repeat (T + 2) tick();
        chk_all("early.hold", 15, 0, 1, 0);
        abort("early");

        // 5a no response: timeout 16 edges after SEND_REQ entry
        withfeb = 1'($urandom_range(0, 1));
        en = 1'b1;
        tick();
        for (int t = 1; t <= T + 2; t++) begin
            if (withfeb && t == 2) sb.i_falling_edge_busy = 1'b1;
            if ($urandom_range(0, 1) == 1) begin
                sb.i_rx_msg_valid   = 1'b1;
                sb.i_decoded_SB_msg = (t % 3 == 0) ? 4'd13 :
                                      4'($urandom_range(0, 13));
            end
            tick();
            quiet();
            chk($sformatf("to.t%0d", t), 32'(to_o), 32'(t >= T));
            chk($sformatf("to.end%0d", t), 32'(end_o), 32'd0);
        end
        send_msg(14);
        chk("to.late_end", 32'(end_o), 32'd0);
        chk("to.late_to", 32'(to_o), 32'd1);
        abort("to");

        // 5c response exactly on the limit cycle
        en = 1'b1;
        tick();
        for (int t = 1; t < T; t++) begin
            if (t == 2) sb.i_falling_edge_busy = 1'b1;
            tick();
            sb.i_falling_edge_busy = 1'b0;
            chk($sformatf("lim.t%0d", t), 32'(to_o), 32'd0);
        end
        send_msg(14);
        chk_all("lim.resp", 15, 0, 1, 0);
        tick();
        chk_all("lim.hold", 15, 0, 1, 0);
        abort("lim");

        // 6a drop enable in WAIT_RESP
        en = 1'b1;
        tick();
        pulse_feb();
        tick();
        en = 1'b0;
        tick();
        chk("drop.end", 32'(end_o), 32'd0);
        chk("drop.to", 32'(to_o), 32'd0);
        chk("drop.valid", 32'(sb.o_valid_tx), 32'd0);
        tick();
        chk_all("drop.idle", 0, 0, 0, 0);

        // 6b asynchronous reset mid SEND_REQ, then a clean rerun
        en = 1'b1;
        tick();
        tick();
        chk("rst.pre", 32'(sb.o_valid_tx), 32'd1);
        i_rst = 1'b1;
        #1;
        chk_all("rst.async", 0, 0, 0, 0);
        en = 1'b0;
        tick();
        i_rst = 1'b0;
        tick();
        chk_all("rst.idle", 0, 0, 0, 0);
        run_nominal("rerun");
        abort("rerun");

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
